// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module : cnn_pkg
// Dimensions, state encoding and saturation helpers shared by the cnn core.
// Optional macro CNN_CONV_RELU_EN selects ReLU conv saturation [0,127].
// Rev    : 1.0
// ============================================================================
package cnn_pkg;

  localparam int IMAGE_WIDTH               = 28;
  localparam int IMAGE_HEIGHT              = 28;
  localparam int NUM_FEATURES              = 3;
  localparam int KERNEL_SIZE               = 4;
  localparam int DATA_WIDTH                = 8;
  localparam int PSUM_DATA_WIDTH           = 13;
  localparam int FULLYCONNECTED_DATA_WIDTH = 32;
  localparam int FC_SHIFT                  = 7;

  localparam int CONV_DIM         = IMAGE_WIDTH - KERNEL_SIZE + 1;
  localparam int CONV_AREA        = CONV_DIM * CONV_DIM;
  localparam int POOL_DIM         = CONV_DIM / 2;
  localparam int POOL_AREA        = POOL_DIM * POOL_DIM;
  localparam int FLATTENED_LENGTH = NUM_FEATURES * POOL_AREA;
  localparam int KERNEL_ELEMS     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ROW_WIDTH        = KERNEL_ELEMS * DATA_WIDTH;
  localparam int FC_ROWS          = FLATTENED_LENGTH / KERNEL_ELEMS;
  localparam int IMG_BITS         = IMAGE_WIDTH * IMAGE_HEIGHT;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE           = 3'd0;
  localparam state_t S_CONVOLUTION    = 3'd1;
  localparam state_t S_POOLING        = 3'd2;
  localparam state_t S_FLATTENING     = 3'd3;
  localparam state_t S_FULLYCONNECTED = 3'd4;
  localparam state_t S_OUTPUT         = 3'd5;

  // Element k of a 16-weight row sits at bits [127-8k -: 8].
  function automatic logic signed [DATA_WIDTH-1:0] elem8(input logic [ROW_WIDTH-1:0] row,
                                                          input logic [3:0] k);
    return $signed(row[{~k, 3'b000} +: DATA_WIDTH]);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_conv(input logic signed [PSUM_DATA_WIDTH-1:0] psum);
`ifdef CNN_CONV_RELU_EN
    if (psum < 13'sd0)        return 8'sd0;
    else if (psum > 13'sd127) return 8'sd127;
    else                      return psum[DATA_WIDTH-1:0];
`else
    if (psum < -13'sd128)     return -8'sd128;
    else if (psum > 13'sd127) return 8'sd127;
    else                      return psum[DATA_WIDTH-1:0];
`endif
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] max_s8(input logic signed [DATA_WIDTH-1:0] a,
                                                           input logic signed [DATA_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] clamp_u8(input logic signed [FULLYCONNECTED_DATA_WIDTH-1:0] y);
    if (y < 32'sd0)        return 8'd0;
    else if (y > 32'sd255) return 8'd255;
    else                   return y[DATA_WIDTH-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_conv_window.sv
`default_nettype none
// ============================================================================
// Module : cnn_conv_window
// One 4x4 binary-pixel window: bias plus selected weights, then saturation.
// Rev    : 1.0
// ============================================================================
module cnn_conv_window
  import cnn_pkg::*;
(
  input  logic [KERNEL_ELEMS-1:0]      pixels,
  input  logic [ROW_WIDTH-1:0]         weights,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [DATA_WIDTH-1:0] result
);

  logic signed [PSUM_DATA_WIDTH-1:0] psum;

  // Pixels are 1-bit, so each product degenerates to gating a weight.
  always_comb begin
    psum = PSUM_DATA_WIDTH'(bias);
    for (int k = 0; k < KERNEL_ELEMS; k++) begin
      if (pixels[k]) psum = psum + PSUM_DATA_WIDTH'(elem8(weights, 4'(k)));
    end
    result = sat_conv(psum);
  end

endmodule
`default_nettype wire

// File: rtl/cnn.sv
`default_nettype none
// ============================================================================
// Module : cnn
// Sequential binary-image CNN: conv(3x4x4) -> 2x2 maxpool -> flatten -> FC.
// Optional macro CNN_CONV_RELU_EN enables ReLU on the convolution output.
// Rev    : 1.0
// ============================================================================
module cnn
  import cnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_cnn,
  input  logic [IMG_BITS-1:0]  image_input,
  input  logic [ROW_WIDTH-1:0] feature_weights_input,
  input  logic [1:0]           feature_writeAddr,
  input  logic                 feature_WrEn,
  input  logic                 rst_feature_weights,
  input  logic [31:0]          bias_weights_input,
  input  logic                 bias_WrEn,
  input  logic                 rst_bias_weights,
  input  logic [ROW_WIDTH-1:0] fullyconnected_weights_input,
  input  logic [4:0]           fullyconnected_writeAddr,
  input  logic                 fullyconnected_WrEn,
  input  logic                 rst_fullyconnected_weights,
  input  logic                 convolution_enable,
  output logic [7:0]           cnn_output
);

  localparam logic [4:0] CONV_LAST = 5'(CONV_DIM - 1);
  localparam logic [4:0] POOL_LAST = 5'(POOL_DIM - 1);
  localparam logic [8:0] FC_LAST   = 9'(FLATTENED_LENGTH - 1);

  state_t state_q, state_d;
  logic [IMG_BITS-1:0] image_q, image_d;
  logic [4:0] row_q, row_d, col_q, col_d;
  logic [8:0] fc_idx_q, fc_idx_d;
  logic signed [FULLYCONNECTED_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [7:0] out_q, out_d;

  logic [ROW_WIDTH-1:0] feat_mem_q [NUM_FEATURES];
  logic [ROW_WIDTH-1:0] feat_mem_d [NUM_FEATURES];
  logic [31:0]          bias_q, bias_d;
  logic [ROW_WIDTH-1:0] fc_mem_q [FC_ROWS];
  logic [ROW_WIDTH-1:0] fc_mem_d [FC_ROWS];
  logic signed [DATA_WIDTH-1:0] conv_mem_q [NUM_FEATURES][CONV_AREA];
  logic signed [DATA_WIDTH-1:0] conv_mem_d [NUM_FEATURES][CONV_AREA];
  logic signed [DATA_WIDTH-1:0] flat_q [FLATTENED_LENGTH];
  logic signed [DATA_WIDTH-1:0] flat_d [FLATTENED_LENGTH];

  logic [KERNEL_ELEMS-1:0]      win_px;
  logic signed [DATA_WIDTH-1:0] conv_res [NUM_FEATURES];
  logic signed [DATA_WIDTH-1:0] pool_res [NUM_FEATURES];
  logic [9:0] conv_idx, pool_base;
  logic [8:0] flat_base;
  logic signed [DATA_WIDTH-1:0]   fc_w;
  logic signed [2*DATA_WIDTH-1:0] fc_prod;
  logic signed [FULLYCONNECTED_DATA_WIDTH-1:0] fc_y;

  function automatic logic pixel_at(input logic [IMG_BITS-1:0] img, input int r, input int c);
    logic [9:0] idx;
    idx = 10'(IMG_BITS - 1 - (r * IMAGE_WIDTH + c));
    return img[idx];
  endfunction

  always_comb begin
    win_px = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
        win_px[i*KERNEL_SIZE + j] = pixel_at(image_q, int'(row_q) + i, int'(col_q) + j);
      end
    end
  end

  generate
    for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_feat
      cnn_conv_window u_win (
        .pixels  (win_px),
        .weights (feat_mem_q[f]),
        .bias    ($signed(bias_q[31-8*f -: 8])),
        .result  (conv_res[f])
      );
    end
  endgenerate

  // Row/col counters double as conv position (0..24) and pooled position (0..11).
  always_comb begin
    conv_idx  = 10'(row_q) * 10'(CONV_DIM) + 10'(col_q);
    pool_base = 10'(row_q) * 10'(2 * CONV_DIM) + 10'(col_q) * 10'd2;
    flat_base = 9'(row_q) * 9'(POOL_DIM) + 9'(col_q);
    for (int f = 0; f < NUM_FEATURES; f++) begin
      pool_res[f] = max_s8(max_s8(conv_mem_q[f][pool_base], conv_mem_q[f][pool_base + 10'd1]),
                           max_s8(conv_mem_q[f][pool_base + 10'(CONV_DIM)],
                                  conv_mem_q[f][pool_base + 10'(CONV_DIM + 1)]));
    end
    fc_w    = elem8(fc_mem_q[fc_idx_q[8:4]], fc_idx_q[3:0]);
    fc_prod = flat_q[fc_idx_q] * fc_w;
    fc_y    = (acc_q >>> FC_SHIFT) + FULLYCONNECTED_DATA_WIDTH'($signed(bias_q[7:0]));
  end

  always_comb begin
    state_d    = state_q;
    image_d    = image_q;
    row_d      = row_q;
    col_d      = col_q;
    fc_idx_d   = fc_idx_q;
    acc_d      = acc_q;
    out_d      = out_q;
    conv_mem_d = conv_mem_q;
    flat_d     = flat_q;
    case (state_q)
      S_IDLE: begin
        if (!convolution_enable) begin
          image_d = image_input;
          row_d   = '0;
          col_d   = '0;
          state_d = S_CONVOLUTION;
        end
      end
      S_CONVOLUTION: begin
        for (int f = 0; f < NUM_FEATURES; f++) conv_mem_d[f][conv_idx] = conv_res[f];
        if (col_q == CONV_LAST) begin
          col_d = '0;
          if (row_q == CONV_LAST) begin
            row_d   = '0;
            state_d = S_POOLING;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          col_d = col_q + 5'd1;
        end
      end
      S_POOLING: begin
        for (int f = 0; f < NUM_FEATURES; f++) flat_d[9'(f * POOL_AREA) + flat_base] = pool_res[f];
        if (col_q == POOL_LAST) begin
          col_d = '0;
          if (row_q == POOL_LAST) begin
            row_d   = '0;
            state_d = S_FLATTENING;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          col_d = col_q + 5'd1;
        end
      end
      S_FLATTENING: begin
        acc_d    = '0;
        fc_idx_d = '0;
        state_d  = S_FULLYCONNECTED;
      end
      S_FULLYCONNECTED: begin
        acc_d = acc_q + FULLYCONNECTED_DATA_WIDTH'(fc_prod);
        if (fc_idx_q == FC_LAST) state_d = S_OUTPUT;
        else                     fc_idx_d = fc_idx_q + 9'd1;
      end
      S_OUTPUT: begin
        out_d   = clamp_u8(fc_y);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Weight memories accept writes only while idle so a running inference is stable.
  always_comb begin
    feat_mem_d = feat_mem_q;
    bias_d     = bias_q;
    fc_mem_d   = fc_mem_q;
    if (state_q == S_IDLE) begin
      if (!feature_WrEn && feature_writeAddr < 2'(NUM_FEATURES))
        feat_mem_d[feature_writeAddr] = feature_weights_input;
      if (!bias_WrEn)
        bias_d = bias_weights_input;
      if (!fullyconnected_WrEn && fullyconnected_writeAddr < 5'(FC_ROWS))
        fc_mem_d[fullyconnected_writeAddr] = fullyconnected_weights_input;
    end
  end

  always_ff @(posedge clk or negedge rst_cnn) begin
    if (!rst_cnn) begin
      state_q  <= S_IDLE;
      image_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      fc_idx_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      image_q  <= image_d;
      row_q    <= row_d;
      col_q    <= col_d;
      fc_idx_q <= fc_idx_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    conv_mem_q <= conv_mem_d;
    flat_q     <= flat_d;
  end

  always_ff @(posedge clk or negedge rst_feature_weights) begin
    if (!rst_feature_weights) feat_mem_q <= '{default: '0};
    else                      feat_mem_q <= feat_mem_d;
  end

  always_ff @(posedge clk or negedge rst_bias_weights) begin
    if (!rst_bias_weights) bias_q <= '0;
    else                   bias_q <= bias_d;
  end

  always_ff @(posedge clk or negedge rst_fullyconnected_weights) begin
    if (!rst_fullyconnected_weights) fc_mem_q <= '{default: '0};
    else                             fc_mem_q <= fc_mem_d;
  end

  assign cnn_output = out_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn.sv
`default_nettype none
// ============================================================================
// Module : tb_cnn
// Directed and randomized checks of the cnn core against a plain-arithmetic model.
// Rev    : 1.0
// ============================================================================
module tb_cnn;

  logic         clk = 1'b0;
  logic         rst_cnn;
  logic [783:0] image_input;
  logic [127:0] feature_weights_input;
  logic [1:0]   feature_writeAddr;
  logic         feature_WrEn;
  logic         rst_feature_weights;
  logic [31:0]  bias_weights_input;
  logic         bias_WrEn;
  logic         rst_bias_weights;
  logic [127:0] fullyconnected_weights_input;
  logic [4:0]   fullyconnected_writeAddr;
  logic         fullyconnected_WrEn;
  logic         rst_fullyconnected_weights;
  logic         convolution_enable;
  logic [7:0]   cnn_output;

  int checks, passed, failed, last_score;
  int fw [3][16];
  int bs [4];
  int fcw [432];
  bit img [28][28];

  always #5 clk = ~clk;

  cnn dut (
    .clk                          (clk),
    .rst_cnn                      (rst_cnn),
    .image_input                  (image_input),
    .feature_weights_input        (feature_weights_input),
    .feature_writeAddr            (feature_writeAddr),
    .feature_WrEn                 (feature_WrEn),
    .rst_feature_weights          (rst_feature_weights),
    .bias_weights_input           (bias_weights_input),
    .bias_WrEn                    (bias_WrEn),
    .rst_bias_weights             (rst_bias_weights),
    .fullyconnected_weights_input (fullyconnected_weights_input),
    .fullyconnected_writeAddr     (fullyconnected_writeAddr),
    .fullyconnected_WrEn          (fullyconnected_WrEn),
    .rst_fullyconnected_weights   (rst_fullyconnected_weights),
    .convolution_enable           (convolution_enable),
    .cnn_output                   (cnn_output)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: conv with saturation, 2x2 max pool, flatten, FC, shift, bias, clamp.
  function automatic int model_score();
    int conv [3][25][25];
    int flat [432];
    int s, m, acc, y, lo;
`ifdef CNN_CONV_RELU_EN
    lo = 0;
`else
    lo = -128;
`endif
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 25; r++)
        for (int c = 0; c < 25; c++) begin
          s = bs[f];
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
              if (img[r+i][c+j]) s += fw[f][i*4+j];
          conv[f][r][c] = (s < lo) ? lo : ((s > 127) ? 127 : s);
        end
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 12; c++) begin
          m = conv[f][2*r][2*c];
          if (conv[f][2*r][2*c+1]   > m) m = conv[f][2*r][2*c+1];
          if (conv[f][2*r+1][2*c]   > m) m = conv[f][2*r+1][2*c];
          if (conv[f][2*r+1][2*c+1] > m) m = conv[f][2*r+1][2*c+1];
          flat[f*144 + r*12 + c] = m;
        end
    acc = 0;
    for (int i = 0; i < 432; i++) acc += flat[i] * fcw[i];
    y = (acc >>> 7) + bs[3];
    return (y < 0) ? 0 : ((y > 255) ? 255 : y);
  endfunction

  task automatic clear_model();
    for (int f = 0; f < 3; f++) for (int k = 0; k < 16; k++) fw[f][k] = 0;
    for (int b = 0; b < 4; b++) bs[b] = 0;
    for (int i = 0; i < 432; i++) fcw[i] = 0;
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = 1'b0;
  endtask

  task automatic randomize_model();
    for (int f = 0; f < 3; f++) for (int k = 0; k < 16; k++) fw[f][k] = int'($urandom_range(0, 255)) - 128;
    for (int b = 0; b < 3; b++) bs[b] = int'($urandom_range(0, 255)) - 128;
    bs[3] = int'($urandom_range(0, 100));
    for (int i = 0; i < 432; i++) fcw[i] = int'($urandom_range(0, 6)) - 3;
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = 1'($urandom_range(0, 1));
  endtask

  task automatic load_all();
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) image_input[783 - (r*28 + c)] = img[r][c];
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      feature_writeAddr = 2'(f);
      for (int k = 0; k < 16; k++) feature_weights_input[127 - 8*k -: 8] = 8'(fw[f][k]);
      feature_WrEn = 1'b0;
    end
    @(negedge clk);
    feature_WrEn       = 1'b1;
    bias_weights_input = {8'(bs[0]), 8'(bs[1]), 8'(bs[2]), 8'(bs[3])};
    bias_WrEn          = 1'b0;
    for (int a = 0; a < 27; a++) begin
      @(negedge clk);
      bias_WrEn = 1'b1;
      fullyconnected_writeAddr = 5'(a);
      for (int k = 0; k < 16; k++) fullyconnected_weights_input[127 - 8*k -: 8] = 8'(fcw[a*16 + k]);
      fullyconnected_WrEn = 1'b0;
    end
    @(negedge clk);
    fullyconnected_WrEn = 1'b1;
  endtask

  // mode 0: plain start pulse; 1: attempt weight writes mid-convolution; 2: start held low.
  task automatic run(input string tag, input int exp_score, input int mode);
    int n;
    @(negedge clk);
    convolution_enable = 1'b0;
    @(posedge clk); #1;
    if (mode != 2) convolution_enable = 1'b1;
    check({tag, "_start"}, 32'(dut.state_q), 1);
    n = 0;
    while (dut.state_q !== 3'd0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (n == 700) check({tag, "_hold"}, 32'(cnn_output), last_score);
      if (mode == 1 && n >= 5 && n < 9) begin
        feature_weights_input        = {$urandom, $urandom, $urandom, $urandom};
        feature_writeAddr            = 2'($urandom_range(0, 2));
        bias_weights_input           = $urandom;
        fullyconnected_weights_input = {$urandom, $urandom, $urandom, $urandom};
        fullyconnected_writeAddr     = 5'($urandom_range(0, 26));
        feature_WrEn = 1'b0; bias_WrEn = 1'b0; fullyconnected_WrEn = 1'b0;
      end
      if (mode == 1 && n == 9) begin
        feature_WrEn = 1'b1; bias_WrEn = 1'b1; fullyconnected_WrEn = 1'b1;
      end
    end
    check({tag, "_cycles"}, n, 1203);
    check({tag, "_score"}, 32'(cnn_output), exp_score);
    last_score = exp_score;
    if (mode == 2) begin
      convolution_enable = 1'b1;
      @(posedge clk); #1;
      check({tag, "_no_restart"}, 32'(dut.state_q), 0);
    end
  endtask

  initial begin
    int n;
    checks = 0; passed = 0; failed = 0; last_score = 0;
    image_input = '0;
    feature_weights_input = '0; feature_writeAddr = '0; feature_WrEn = 1'b1;
    bias_weights_input = '0; bias_WrEn = 1'b1;
    fullyconnected_weights_input = '0; fullyconnected_writeAddr = '0; fullyconnected_WrEn = 1'b1;
    convolution_enable = 1'b1;
    rst_cnn = 1'b0; rst_feature_weights = 1'b0; rst_bias_weights = 1'b0; rst_fullyconnected_weights = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(dut.state_q), 0);
    check("reset_output", 32'(cnn_output), 0);
    @(negedge clk);
    rst_cnn = 1'b1; rst_feature_weights = 1'b1; rst_bias_weights = 1'b1; rst_fullyconnected_weights = 1'b1;
    @(posedge clk); #1;
    check("idle_without_start", 32'(dut.state_q), 0);

    clear_model();
    bs[0] = 10; bs[3] = -8;
    for (int i = 0; i < 432; i++) fcw[i] = 1;
    load_all();
    run("zero_image", 3, 0);

    // Abort during the FC phase.
    @(negedge clk);
    convolution_enable = 1'b0;
    @(posedge clk); #1;
    convolution_enable = 1'b1;
    n = 0;
    while (dut.state_q !== 3'd4 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reach_fc", n, 770);
    repeat (20) @(posedge clk);
    #3 rst_cnn = 1'b0;
    #1;
    check("abort_state", 32'(dut.state_q), 0);
    check("abort_output", 32'(cnn_output), 0);
    @(negedge clk);
    rst_cnn = 1'b1;
    last_score = 0;
    @(posedge clk); #1;
    check("abort_stays_idle", 32'(dut.state_q), 0);
    run("after_abort", 3, 0);

    bs[3] = -20;
    load_all();
    run("clamp_low", 0, 0);

    clear_model();
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = 1'b1;
    for (int k = 0; k < 16; k++) fw[0][k] = 127;
    bs[0] = 10;
    fcw[0] = 127;
    load_all();
    run("saturate", 126, 0);

    // Writes that must be ignored: WrEn high, feature addr 3, FC addr beyond row 26.
    @(negedge clk);
    feature_weights_input        = {$urandom, $urandom, $urandom, $urandom};
    bias_weights_input           = $urandom;
    fullyconnected_weights_input = {$urandom, $urandom, $urandom, $urandom};
    feature_writeAddr = 2'd0; fullyconnected_writeAddr = 5'd0;
    @(negedge clk);
    feature_writeAddr = 2'd3; feature_WrEn = 1'b0;
    fullyconnected_writeAddr = 5'd27; fullyconnected_WrEn = 1'b0;
    @(negedge clk);
    fullyconnected_writeAddr = 5'd31;
    @(negedge clk);
    feature_WrEn = 1'b1; fullyconnected_WrEn = 1'b1;
    run("ignored_writes", 126, 0);
    run("busy_writes", 126, 1);
    run("after_busy_writes", 126, 0);
    run("start_held", 126, 2);

    for (int t = 0; t < 3; t++) begin
      randomize_model();
      load_all();
      run($sformatf("random%0d", t), model_score(), 0);
    end

    @(negedge clk);
    rst_feature_weights = 1'b0;
    @(negedge clk);
    rst_feature_weights = 1'b1;
    for (int f = 0; f < 3; f++) for (int k = 0; k < 16; k++) fw[f][k] = 0;
    run("feature_clear", model_score(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
